pifo_enq_admission: RTL and testbench

- Admission-control stage directly upstream of the PIFO scheduler on the SUME datapath.
- Takes AXI-Stream packets with SUME metadata and resolves the destination queue from tuser.
- Tracks per-port buffer byte occupancy and decides admit or drop on the first beat, so the PIFO never receives a packet it cannot buffer.
- Dropped packets are fully consumed upstream and never appear downstream; the PIFO reports freed bytes back on a release port.

---
 rtl/pifo_enq_admission.sv | 215 +++++++++++++++++++++
 tb/tb_pifo_enq_admission.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_enq_admission.sv
// pifo_enq_admission
// Admission stage in front of the PIFO scheduler. Resolves the destination
// queue from the SUME dst_port field, tracks per-queue buffer occupancy and
// decides admit/drop on the first beat of each packet. Admitted packets pass
// through combinationally with the queue index in tuser[34:32]; dropped
// packets are swallowed. The PIFO returns freed bytes on the rel_* port.
//
// Optional build macro: PIFO_ADM_STATS_EN adds adm_bytes, a wrapping 32-bit
// admitted-byte counter per queue (port 0 at the LSBs).
//
// state | meaning
// IDLE  | next beat is a first beat; admit/drop decided combinationally
// PASS  | forwarding the remaining beats of an admitted packet
// DROP  | consuming the remaining beats of a dropped packet
module pifo_enq_admission #(
    parameter int DATA_WIDTH      = 256,
    parameter int SUME_META_WIDTH = 128,
    parameter int PORT_NUM        = 5,
    parameter int PKT_BUFFER_SIZE = 128000,
    parameter int MIN_PKT_SIZE    = 64,
    parameter int MAX_PKT_SIZE    = 1518
) (
    input  logic                       clk_in_0,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [SUME_META_WIDTH-1:0] s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [SUME_META_WIDTH-1:0] m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    input  logic                       rel_valid,
    input  logic [2:0]                 rel_port,
    input  logic [15:0]                rel_len,
    output logic                       drop_pulse,
    output logic [31:0]                drop_count
`ifdef PIFO_ADM_STATS_EN
    ,
    output logic [PORT_NUM*32-1:0]     adm_bytes
`endif
);

    localparam int OCC_W = $clog2(PKT_BUFFER_SIZE) + 1;
    localparam int SUM_W = OCC_W + 1;

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t               state, state_nxt;
    logic [OCC_W-1:0]     occ      [PORT_NUM];
    logic [OCC_W-1:0]     occ_nxt  [PORT_NUM];
    logic [SUM_W-1:0]     occ_sum  [PORT_NUM];
    logic [SUM_W-1:0]     occ_sub  [PORT_NUM];
    logic [OCC_W-1:0]     occ_sel;
    logic [2:0]           idx_dec, idx_lat, idx_out;
    logic                 idx_legal, len_ok, fits, admit;
    logic [7:0]           dst;
    logic [15:0]          pkt_len;
    logic [3:0]           dst_even, dst_odd;
    logic                 s_ready_c, m_valid_c, drop_c, adm_hs;
    logic [SUME_META_WIDTH-1:0] tuser_out;

    assign dst      = s_axis_tuser[31:24];
    assign pkt_len  = s_axis_tuser[15:0];
    assign dst_even = {dst[6], dst[4], dst[2], dst[0]};
    assign dst_odd  = {dst[7], dst[5], dst[3], dst[1]};

    // Queue decode: a single even bit selects nf0-nf3, odd-only selects DMA.
    always_comb begin
        idx_dec   = 3'd0;
        idx_legal = 1'b0;
        if (dst_odd == 4'b0000) begin
            case (dst_even)
                4'b0001: begin idx_dec = 3'd0; idx_legal = 1'b1; end
                4'b0010: begin idx_dec = 3'd1; idx_legal = 1'b1; end
                4'b0100: begin idx_dec = 3'd2; idx_legal = 1'b1; end
                4'b1000: begin idx_dec = 3'd3; idx_legal = 1'b1; end
                default: begin idx_dec = 3'd0; idx_legal = 1'b0; end
            endcase
        end else if (dst_even == 4'b0000) begin
            idx_dec   = 3'd4;
            idx_legal = 1'b1;
        end
    end

    // Occupancy of the decoded queue, used by the admission check.
    always_comb begin
        occ_sel = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (idx_dec == p[2:0]) occ_sel = occ[p];
        end
    end

    // Fit check is one bit wider than the counter so it can never wrap.
    assign len_ok = (pkt_len >= 16'(MIN_PKT_SIZE)) && (pkt_len <= 16'(MAX_PKT_SIZE));
    assign fits   = ({1'b0, occ_sel} + SUM_W'(pkt_len)) <= SUM_W'(PKT_BUFFER_SIZE);
    assign admit  = idx_legal & len_ok & fits;

    // Next-state and handshake routing.
    always_comb begin
        state_nxt = state;
        s_ready_c = 1'b0;
        m_valid_c = 1'b0;
        drop_c    = 1'b0;
        adm_hs    = 1'b0;
        idx_out   = idx_lat;
        case (state)
            IDLE: begin
                idx_out = idx_dec;
                if (admit) begin
                    m_valid_c = s_axis_tvalid;
                    s_ready_c = m_axis_tready;
                    if (s_axis_tvalid && m_axis_tready) begin
                        adm_hs = 1'b1;
                        if (!s_axis_tlast) state_nxt = PASS;
                    end
                end else begin
                    s_ready_c = 1'b1;
                    if (s_axis_tvalid) begin
                        drop_c = 1'b1;
                        if (!s_axis_tlast) state_nxt = DROP;
                    end
                end
            end
            PASS: begin
                m_valid_c = s_axis_tvalid;
                s_ready_c = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nxt = IDLE;
            end
            DROP: begin
                s_ready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Forwarded metadata with the queue index overlaid on bits [34:32].
    always_comb begin
        tuser_out        = s_axis_tuser;
        tuser_out[34:32] = idx_out;
    end

    // Outputs are held at zero while reset is asserted, even though the
    // data path is combinational from the slave side.
    assign s_axis_tready = reset & s_ready_c;
    assign m_axis_tvalid = reset & m_valid_c;
    assign drop_pulse    = reset & drop_c;
    assign m_axis_tdata  = reset ? s_axis_tdata : '0;
    assign m_axis_tkeep  = reset ? s_axis_tkeep : '0;
    assign m_axis_tlast  = reset & s_axis_tlast;
    assign m_axis_tuser  = reset ? tuser_out : '0;

    // Per-queue update: add admitted length, subtract release, floor at 0.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            occ_sum[p] = {1'b0, occ[p]};
            occ_sub[p] = '0;
            if (adm_hs && (idx_dec == p[2:0])) occ_sum[p] = {1'b0, occ[p]} + SUM_W'(pkt_len);
            if (rel_valid && (rel_port == p[2:0])) occ_sub[p] = SUM_W'(rel_len);
            occ_nxt[p] = (occ_sum[p] >= occ_sub[p]) ? OCC_W'(occ_sum[p] - occ_sub[p]) : '0;
        end
    end

    // State register.
    always_ff @(posedge clk_in_0 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Occupancy counters.
    always_ff @(posedge clk_in_0 or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < PORT_NUM; p++) occ[p] <= '0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) occ[p] <= occ_nxt[p];
        end
    end

    // Latch the queue index of an admitted packet for its remaining beats.
    always_ff @(posedge clk_in_0 or negedge reset) begin
        if (!reset)      idx_lat <= 3'd0;
        else if (adm_hs) idx_lat <= idx_dec;
    end

    // Saturating drop counter.
    always_ff @(posedge clk_in_0 or negedge reset) begin
        if (!reset)                             drop_count <= '0;
        else if (drop_c && (drop_count != '1)) drop_count <= drop_count + 32'd1;
    end

`ifdef PIFO_ADM_STATS_EN
    logic [31:0] adm_cnt [PORT_NUM];

    // Wrapping admitted-byte counters per queue.
    always_ff @(posedge clk_in_0 or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < PORT_NUM; p++) adm_cnt[p] <= '0;
        end else if (adm_hs) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (idx_dec == p[2:0]) adm_cnt[p] <= adm_cnt[p] + 32'(pkt_len);
            end
        end
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_stats
        assign adm_bytes[g*32 +: 32] = adm_cnt[g];
    end
`endif

endmodule

// File: tb/tb_pifo_enq_admission.sv
// Testbench for pifo_enq_admission: directed scenarios plus randomized
// traffic, checked against a per-queue byte-occupancy model.
module tb_pifo_enq_admission;

    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int KW  = DW / 8;
    localparam int BUF = 128000;

    logic          clk_in_0 = 1'b0;
    logic          reset    = 1'b0;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic [KW-1:0] s_axis_tkeep  = '0;
    logic [UW-1:0] s_axis_tuser  = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast  = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          rel_valid = 1'b0;
    logic [2:0]    rel_port  = '0;
    logic [15:0]   rel_len   = '0;
    logic          drop_pulse;
    logic [31:0]   drop_count;
`ifdef PIFO_ADM_STATS_EN
    logic [5*32-1:0] adm_bytes;
`endif

    always #5 clk_in_0 = ~clk_in_0;

    pifo_enq_admission dut (
        .clk_in_0      (clk_in_0),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .rel_valid     (rel_valid),
        .rel_port      (rel_port),
        .rel_len       (rel_len),
        .drop_pulse    (drop_pulse),
`ifdef PIFO_ADM_STATS_EN
        .adm_bytes     (adm_bytes),
`endif
        .drop_count    (drop_count)
    );

    int errors = 0;
    int checks = 0;
    int occ_m [5];
    longint drops_m = 0;

    // Reference decode: count set even/odd bits of dst_port.
    function automatic int qidx(input logic [7:0] d);
        int ne = 0, no = 0, ei = -1;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                if (i % 2 == 0) begin ne++; ei = i / 2; end
                else no++;
            end
        end
        if (ne == 1 && no == 0) return ei;
        if (ne == 0 && no > 0) return 4;
        return -1;
    endfunction

    function automatic bit exp_admit(input logic [7:0] dst, input int len);
        int i = qidx(dst);
        if (i < 0) return 1'b0;
        if (len < 64 || len > 1518) return 1'b0;
        return (occ_m[i] + len) <= BUF;
    endfunction

    function automatic void model_release(input logic v, input logic [2:0] p, input logic [15:0] l);
        int pi = int'(p);
        if (v && pi < 5) begin
            occ_m[pi] = occ_m[pi] - int'(l);
            if (occ_m[pi] < 0) occ_m[pi] = 0;
        end
    endfunction

    // Sends one packet; entered and left one time unit after a rising edge.
    task automatic send_pkt(input logic [7:0] dst, input int len, input int nbeats,
                            input int first_stall, input int stall_pct,
                            input logic rel0_v, input logic [2:0] rel0_p, input int rel0_l,
                            input int rel_pct, input int abort_after);
        int idx;
        bit adm, first, hs;
        logic [2:0] ix;
        logic [UW-1:0] u, eu;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int cyc;
        idx = qidx(dst);
        ix  = (idx >= 0) ? 3'(idx) : 3'd0;
        adm = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
            for (int w = 0; w < UW / 32; w++) u[w*32 +: 32] = $urandom;
            k = $urandom;
            if (b == 0) begin
                u[15:0]  = len[15:0];
                u[31:24] = dst;
            end
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tuser  = u;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (b == nbeats - 1);
            first = (b == 0);
            cyc = 0;
            while (1) begin
                if (first) adm = exp_admit(dst, len);
                if (first && cyc < first_stall) m_axis_tready = 1'b0;
                else if (cyc > 100)             m_axis_tready = 1'b1;
                else m_axis_tready = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
                if (first && cyc == 0 && rel0_v) begin
                    rel_valid = 1'b1; rel_port = rel0_p; rel_len = rel0_l[15:0];
                end else if ($urandom_range(0, 99) < rel_pct) begin
                    rel_valid = 1'b1;
                    rel_port  = 3'($urandom_range(0, 7));
                    rel_len   = 16'($urandom_range(0, 3000));
                end else begin
                    rel_valid = 1'b0;
                end
                #1;
                checks++;
                if (s_axis_tready !== (adm ? m_axis_tready : 1'b1)) begin
                    errors++;
                    $display("FAIL s_tready pkt dst=%0h beat=%0d: got %0b expected %0b",
                             dst, b, s_axis_tready, adm ? m_axis_tready : 1'b1);
                end
                checks++;
                if (m_axis_tvalid !== adm) begin
                    errors++;
                    $display("FAIL m_tvalid pkt dst=%0h len=%0d beat=%0d: got %0b expected %0b",
                             dst, len, b, m_axis_tvalid, adm);
                end
                checks++;
                if (drop_pulse !== (first && !adm)) begin
                    errors++;
                    $display("FAIL drop_pulse pkt dst=%0h beat=%0d: got %0b expected %0b",
                             dst, b, drop_pulse, first && !adm);
                end
                if (adm) begin
                    eu = u;
                    eu[34:32] = ix;
                    checks++;
                    if (m_axis_tdata !== d || m_axis_tkeep !== k || m_axis_tlast !== s_axis_tlast) begin
                        errors++;
                        $display("FAIL data beat=%0d: got %0h/%0h/%0b expected %0h/%0h/%0b", b,
                                 m_axis_tdata[63:0], m_axis_tkeep, m_axis_tlast, d[63:0], k, s_axis_tlast);
                    end
                    checks++;
                    if (m_axis_tuser !== eu) begin
                        errors++;
                        $display("FAIL tuser beat=%0d: got %0h expected %0h", b, m_axis_tuser, eu);
                    end
                end
                hs = adm ? m_axis_tready : 1'b1;
                @(posedge clk_in_0);
                if (first && hs && adm)  occ_m[idx] = occ_m[idx] + len;
                if (first && hs && !adm && drops_m < 64'hFFFF_FFFF) drops_m++;
                model_release(rel_valid, rel_port, rel_len);
                #1;
                cyc++;
                if (hs) break;
            end
            if (abort_after > 0 && b == abort_after - 1) break;
        end
        rel_valid = 1'b0;
        m_axis_tready = 1'b1;
        if (abort_after == 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            #1;
            checks++;
            if (drop_count !== 32'(drops_m)) begin
                errors++;
                $display("FAIL drop_count after pkt dst=%0h len=%0d: got %0d expected %0d",
                         dst, len, drop_count, drops_m);
            end
            @(posedge clk_in_0);
            #1;
        end
    endtask

    task automatic idle_rel(input logic [2:0] p, input int l);
        s_axis_tvalid = 1'b0;
        rel_valid = 1'b1;
        rel_port  = p;
        rel_len   = l[15:0];
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle m_tvalid: got %0b expected 0", m_axis_tvalid);
        end
        @(posedge clk_in_0);
        model_release(rel_valid, rel_port, rel_len);
        #1;
        rel_valid = 1'b0;
    endtask

    task automatic fill(input logic [7:0] dst, input int target);
        int i, rem, l;
        i = qidx(dst);
        while (occ_m[i] < target) begin
            rem = target - occ_m[i];
            if (rem > 1582)      l = 1518;
            else if (rem > 1518) l = rem / 2;
            else                 l = rem;
            send_pkt(dst, l, 1, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: got rdy=%0b vld=%0b drp=%0b expected 0/0/0",
                     tag, s_axis_tready, m_axis_tvalid, drop_pulse);
        end
        checks++;
        if (drop_count !== 32'd0) begin
            errors++;
            $display("FAIL %s drop_count: got %0d expected 0", tag, drop_count);
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL %s data: got %0h/%0h expected 0/0", tag, m_axis_tdata[63:0], m_axis_tuser);
        end
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = {8{32'hDEAD_BEEF}};
        s_axis_tuser  = {96'h0, 8'h04, 8'h00, 16'd100};
        s_axis_tkeep  = '1;
        #13;
        check_reset_outputs("reset");
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int p = 0; p < 5; p++) occ_m[p] = 0;
        drops_m = 0;
        @(negedge clk_in_0);
        reset = 1'b1;
        @(posedge clk_in_0);
        #1;
    endtask

    task automatic test_admit();
        send_pkt(8'h04, 100, 4, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h40, 500, 2, 0, 0, 1'b0, 3'd0, 0, 0, 0);
    endtask

    task automatic test_full_buffer();
        fill(8'h01, 127950);
        send_pkt(8'h01, 64, 3, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        idle_rel(3'd0, 14);
        send_pkt(8'h01, 64, 2, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h01, 64, 1, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        idle_rel(3'd0, 65535);
        idle_rel(3'd0, 65535);
        idle_rel(3'd0, 65535);
        send_pkt(8'h01, 1518, 2, 0, 0, 1'b0, 3'd0, 0, 0, 0);
    endtask

    task automatic test_illegal();
        send_pkt(8'h00, 100, 2, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h05, 100, 3, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h10, 63, 1, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h10, 1519, 2, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h03, 100, 2, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h02, 64, 2, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'hA0, 1518, 1, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h10, 1518, 3, 0, 0, 1'b0, 3'd0, 0, 0, 0);
    endtask

    task automatic test_release_admit();
        fill(8'h10, 127900);
        send_pkt(8'h10, 150, 2, 0, 0, 1'b1, 3'd2, 200, 0, 0);
        send_pkt(8'h10, 150, 3, 0, 0, 1'b0, 3'd0, 0, 0, 0);
    endtask

    task automatic test_back_pressure();
        send_pkt(8'h10, 100, 3, 10, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h10, 64, 1, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        idle_rel(3'd2, 14);
        send_pkt(8'h10, 64, 2, 3, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h10, 64, 1, 0, 0, 1'b0, 3'd0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] dsts [13];
        dsts = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h02, 8'h08, 8'h20, 8'h80,
                 8'hAA, 8'h00, 8'h05, 8'h03, 8'hC0};
        for (int n = 0; n < 60; n++) begin
            send_pkt(dsts[$urandom_range(0, 12)], int'($urandom_range(40, 1600)),
                     int'($urandom_range(1, 4)), 0, 30, 1'b0, 3'd0, 0, 20, 0);
        end
    endtask

    task automatic test_reset_mid();
        fill(8'h01, 127950);
        idle_rel(3'd3, 65535);
        idle_rel(3'd3, 65535);
        send_pkt(8'h40, 300, 5, 0, 0, 1'b0, 3'd0, 0, 0, 2);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {8{32'hA5A5_5A5A}};
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int p = 0; p < 5; p++) occ_m[p] = 0;
        drops_m = 0;
        @(negedge clk_in_0);
        reset = 1'b1;
        @(posedge clk_in_0);
        #1;
        send_pkt(8'h01, 1518, 3, 0, 0, 1'b0, 3'd0, 0, 0, 0);
        send_pkt(8'h00, 100, 1, 0, 0, 1'b0, 3'd0, 0, 0, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_admit();
        test_full_buffer();
        test_illegal();
        test_release_admit();
        test_back_pressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
